// File: rtl/sync_event_tx.sv
// Source-side transmitter of a two-phase toggle handshake; queues events while a handshake is in flight.
// Optional ack watchdog enabled by defining SYNC_EVENT_TX_TIMEOUT_EN.
module sync_event_tx #(
    parameter int N_SYNC         = 2,
    parameter int PENDING_W      = 4,
    parameter int CNTR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cg,
    input  logic                 i_evt,
    input  logic                 i_ackToggle,
    output logic                 o_reqToggle,
    output logic                 o_busy,
    output logic [PENDING_W-1:0] o_nPending,
    output logic [CNTR_W-1:0]    o_nSent,
    output logic [CNTR_W-1:0]    o_nDropped,
    output logic                 o_overflow,
    output logic                 o_protoErr,
    output logic                 o_timeout
);

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    localparam logic [PENDING_W-1:0] PEND_MAX = '1;

    state_t                state_q, state_next;
    logic [N_SYNC:0]       sync_q;
    logic                  ack_synced, ack_prev;
    logic                  req_q, req_next;
    logic [PENDING_W-1:0]  pending_q, pending_next;
    logic [CNTR_W-1:0]     sent_q, sent_next;
    logic [CNTR_W-1:0]     dropped_q, dropped_next;
    logic                  overflow_q, overflow_next;
    logic                  proto_q, proto_next;

    // The extra top flop exists only to detect edges of the synchronized ack.
    assign ack_synced = sync_q[N_SYNC-1];
    assign ack_prev   = sync_q[N_SYNC];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else if (i_cg) begin
            sync_q <= {sync_q[N_SYNC-1:0], i_ackToggle};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            pending_q  <= '0;
            sent_q     <= '0;
            dropped_q  <= '0;
            overflow_q <= 1'b0;
            proto_q    <= 1'b0;
        end else if (i_cg) begin
            state_q    <= state_next;
            req_q      <= req_next;
            pending_q  <= pending_next;
            sent_q     <= sent_next;
            dropped_q  <= dropped_next;
            overflow_q <= overflow_next;
            proto_q    <= proto_next;
        end
    end

    always_comb begin
        state_next    = state_q;
        req_next      = req_q;
        pending_next  = pending_q;
        sent_next     = sent_q;
        dropped_next  = dropped_q;
        overflow_next = overflow_q;
        proto_next    = proto_q;
        case (state_q)
            IDLE: begin
                // A queued event is replayed first; a fresh event then takes its queue slot.
                if (i_evt || (pending_q != '0)) begin
                    req_next   = ~req_q;
                    state_next = WAIT_ACK;
                    if ((pending_q != '0) && !i_evt) begin
                        pending_next = pending_q - 1'b1;
                    end
                end
                if (ack_synced != ack_prev) begin
                    proto_next = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (i_evt) begin
                    if (pending_q != PEND_MAX) begin
                        pending_next = pending_q + 1'b1;
                    end else begin
                        dropped_next  = dropped_q + 1'b1;
                        overflow_next = 1'b1;
                    end
                end
                if (ack_synced == req_q) begin
                    sent_next  = sent_q + 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SYNC_EVENT_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    // Counter parks at the limit; the FSM keeps waiting, only the sticky flag reports it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt    <= '0;
            timeout_q <= 1'b0;
        end else if (i_cg) begin
            if ((state_q == IDLE) && (state_next == WAIT_ACK)) begin
                to_cnt <= '0;
            end else if ((state_q == WAIT_ACK) && (to_cnt != TO_LIMIT)) begin
                to_cnt <= to_cnt + 1'b1;
                if (to_cnt == TO_LAST) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_reqToggle = req_q;
    assign o_busy      = (state_q == WAIT_ACK);
    assign o_nPending  = pending_q;
    assign o_nSent     = sent_q;
    assign o_nDropped  = dropped_q;
    assign o_overflow  = overflow_q;
    assign o_protoErr  = proto_q;

endmodule

// File: tb/tb_sync_event_tx.sv
// Self-checking bench for sync_event_tx: req toggles are checked against a scoreboard queue,
// counters and flags are checked inline per scenario. Define SYNC_EVENT_TX_TIMEOUT_EN to exercise the watchdog.
module tb_sync_event_tx;

    localparam int N_SYNC    = 2;
    localparam int PENDING_W = 2;
    localparam int CNTR_W    = 8;
    localparam int TO_CYC    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cg = 1'b1;
    logic evt = 1'b0;
    logic loop_en = 1'b0;
    logic ack_force = 1'b0;
    logic ack_d1, ack_d2, ack_in;

    logic                 req, busy, overflow, proto_err, timeout;
    logic [PENDING_W-1:0] n_pending;
    logic [CNTR_W-1:0]    n_sent, n_dropped;

    int n_compared = 0;
    int n_mismatched = 0;

    bit sb[$];
    bit last_push = 1'b0;
    logic prev_req = 1'b0;

    always #5 clk = ~clk;

    // Far domain model: ack returns the req level after two clocks when looped back.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_d1 <= 1'b0;
            ack_d2 <= 1'b0;
        end else begin
            ack_d1 <= req;
            ack_d2 <= ack_d1;
        end
    end
    assign ack_in = loop_en ? ack_d2 : ack_force;

    sync_event_tx #(
        .N_SYNC(N_SYNC), .PENDING_W(PENDING_W), .CNTR_W(CNTR_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_cg(cg), .i_evt(evt), .i_ackToggle(ack_in),
        .o_reqToggle(req), .o_busy(busy), .o_nPending(n_pending), .o_nSent(n_sent),
        .o_nDropped(n_dropped), .o_overflow(overflow), .o_protoErr(proto_err), .o_timeout(timeout)
    );

    // Each req toggle must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && (req !== prev_req)) begin
            n_compared++;
            if (sb.size() == 0) begin
                n_mismatched++;
                $display("[TB] FAIL req_toggle: got %0b with no launch expected", req);
            end else begin
                bit exp_req;
                exp_req = sb.pop_front();
                if (req !== exp_req) begin
                    n_mismatched++;
                    $display("[TB] FAIL req_toggle: got %0b expected %0b", req, exp_req);
                end
            end
        end
        prev_req = req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_launch();
        last_push = ~last_push;
        sb.push_back(last_push);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        evt = 1'b0;
        cg = 1'b1;
        loop_en = 1'b0;
        ack_force = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        last_push = 1'b0;
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(output int cycles);
        cycles = 0;
        while ((busy || (n_pending != 0) || (sb.size() != 0)) && (cycles < 300)) begin
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_compared++;
        if ({req, busy, overflow, proto_err, timeout} !== 5'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {req, busy, overflow, proto_err, timeout});
        end
        n_compared++;
        if ({n_pending, n_sent, n_dropped} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_counts: got p=%0d s=%0d d=%0d expected 0", n_pending, n_sent, n_dropped);
        end
    endtask

    task automatic test_single_event();
        int n;
        do_reset();
        loop_en = 1'b1;
        evt = 1'b1;
        push_launch();
        tick();
        evt = 1'b0;
        n_compared++;
        if (req !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL single_req: got %0b expected 1", req);
        end
        n = 0;
        while (busy && (n < 50)) begin
            n++;
            tick();
        end
        n_compared++;
        if (n != N_SYNC + 3) begin
            n_mismatched++;
            $display("[TB] FAIL single_busy_len: got %0d expected %0d", n, N_SYNC + 3);
        end
        n_compared++;
        if ((n_sent !== 8'd1) || (n_pending !== 2'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL single_counts: got s=%0d p=%0d expected s=1 p=0", n_sent, n_pending);
        end
    endtask

    task automatic test_queue_replay();
        int n;
        do_reset();
        loop_en = 1'b1;
        evt = 1'b1;
        push_launch();
        tick();
        repeat (3) begin
            push_launch();
            tick();
        end
        evt = 1'b0;
        n_compared++;
        if ((n_pending !== 2'd3) || (busy !== 1'b1)) begin
            n_mismatched++;
            $display("[TB] FAIL queue_fill: got p=%0d busy=%0b expected p=3 busy=1", n_pending, busy);
        end
        wait_drain(n);
        n_compared++;
        if (n >= 300) begin
            n_mismatched++;
            $display("[TB] FAIL queue_drain: got %0d cycles expected < 300", n);
        end
        n_compared++;
        if ((n_sent !== 8'd4) || (n_pending !== 2'd0) || (proto_err !== 1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL queue_counts: got s=%0d p=%0d perr=%0b expected s=4 p=0 perr=0", n_sent, n_pending, proto_err);
        end
    endtask

    task automatic test_saturation();
        int n;
        do_reset();
        evt = 1'b1;
        repeat (4) begin
            push_launch();
            tick();
        end
        tick();
        evt = 1'b0;
        n_compared++;
        if ((n_pending !== 2'd3) || (n_dropped !== 8'd1) || (overflow !== 1'b1) || (req !== 1'b1)) begin
            n_mismatched++;
            $display("[TB] FAIL sat_state: got p=%0d d=%0d ovf=%0b req=%0b expected p=3 d=1 ovf=1 req=1", n_pending, n_dropped, overflow, req);
        end
        loop_en = 1'b1;
        wait_drain(n);
        n_compared++;
        if ((n >= 300) || (n_sent !== 8'd4) || (n_dropped !== 8'd1) || (overflow !== 1'b1)) begin
            n_mismatched++;
            $display("[TB] FAIL sat_drain: got cyc=%0d s=%0d d=%0d ovf=%0b expected s=4 d=1 ovf=1", n, n_sent, n_dropped, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        loop_en = 1'b1;
        evt = 1'b1;
        push_launch();
        tick();
        evt = 1'b0;
        repeat (4) tick();
        evt = 1'b1;
        push_launch();
        tick();
        evt = 1'b0;
        n_compared++;
        if ((busy !== 1'b0) || (n_pending !== 2'd1) || (n_sent !== 8'd1) || (req !== 1'b1)) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_idle: got busy=%0b p=%0d s=%0d req=%0b expected 0 1 1 1", busy, n_pending, n_sent, req);
        end
        tick();
        n_compared++;
        if ((busy !== 1'b1) || (n_pending !== 2'd0) || (req !== 1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_relaunch: got busy=%0b p=%0d req=%0b expected 1 0 0", busy, n_pending, req);
        end
        wait_drain(n);
        n_compared++;
        if ((n >= 300) || (n_sent !== 8'd2)) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_drain: got cyc=%0d s=%0d expected s=2", n, n_sent);
        end
    endtask

    task automatic test_clock_gate();
        int n;
        do_reset();
        loop_en = 1'b1;
        cg = 1'b0;
        evt = 1'b1;
        repeat (3) tick();
        evt = 1'b0;
        n_compared++;
        if ((req !== 1'b0) || (busy !== 1'b0) || (n_pending !== 2'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL cg_idle: got req=%0b busy=%0b p=%0d expected 0 0 0", req, busy, n_pending);
        end
        cg = 1'b1;
        evt = 1'b1;
        push_launch();
        tick();
        cg = 1'b0;
        repeat (10) tick();
        evt = 1'b0;
        n_compared++;
        if ((busy !== 1'b1) || (n_sent !== 8'd0) || (n_pending !== 2'd0) || (n_dropped !== 8'd0)) begin
            n_mismatched++;
            $display("[TB] FAIL cg_frozen: got busy=%0b s=%0d p=%0d d=%0d expected 1 0 0 0", busy, n_sent, n_pending, n_dropped);
        end
        cg = 1'b1;
        wait_drain(n);
        n_compared++;
        if ((n >= 300) || (n_sent !== 8'd1) || (busy !== 1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL cg_resume: got cyc=%0d s=%0d busy=%0b expected s=1 busy=0", n, n_sent, busy);
        end
    endtask

    task automatic test_proto_err();
        do_reset();
        repeat (3) tick();
        n_compared++;
        if (proto_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL perr_quiet: got %0b expected 0", proto_err);
        end
        ack_force = 1'b1;
        repeat (N_SYNC) tick();
        n_compared++;
        if (proto_err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL perr_early: got %0b expected 0", proto_err);
        end
        tick();
        n_compared++;
        if ((proto_err !== 1'b1) || (req !== 1'b0) || (busy !== 1'b0)) begin
            n_mismatched++;
            $display("[TB] FAIL perr_set: got perr=%0b req=%0b busy=%0b expected 1 0 0", proto_err, req, busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        evt = 1'b1;
        repeat (3) begin
            push_launch();
            tick();
        end
        evt = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if ({req, busy, n_pending, n_sent, n_dropped, overflow, proto_err, timeout} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid: got req=%0b busy=%0b p=%0d s=%0d d=%0d expected all 0", req, busy, n_pending, n_sent, n_dropped);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        do_reset();
        evt = 1'b1;
        push_launch();
        tick();
        evt = 1'b0;
`ifdef SYNC_EVENT_TX_TIMEOUT_EN
        repeat (TO_CYC - 1) tick();
        n_compared++;
        if (timeout !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_early: got %0b expected 0", timeout);
        end
        tick();
        n_compared++;
        if ((timeout !== 1'b1) || (busy !== 1'b1)) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_set: got to=%0b busy=%0b expected 1 1", timeout, busy);
        end
`else
        repeat (3 * TO_CYC) tick();
        n_compared++;
        if ((timeout !== 1'b0) || (busy !== 1'b1)) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_tied: got to=%0b busy=%0b expected 0 1", timeout, busy);
        end
`endif
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if ({req, busy, n_pending, n_sent, n_dropped, overflow, proto_err, timeout} !== '0) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_reset: got req=%0b busy=%0b to=%0b expected all 0", req, busy, timeout);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_queue_replay();
        test_saturation();
        test_back_to_back();
        test_clock_gate();
        test_proto_err();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
